syncupcnt_bcd2: RTL

- Two-digit synchronous BCD up-counter (tens:ones) with a programmable limit.
- Counterpart of the single-digit down-counting timer digit: this block counts elapsed time up from a user-set preset.
- Shares that digit's control vocabulary: setting, pb_set, pause, stop.
- Sits between the tick prescaler and the 7-segment/LED display path. Drives the display digits and a carry/done indication to the next stage.

---
 rtl/syncupcnt_bcd2.sv | 127 ++++++++++++
 1 files changed

// File: rtl/syncupcnt_bcd2.sv
// Two-digit BCD up-counter (tens:ones) with a settable preset and a
// programmable terminal count that either wraps with a carry or saturates.
module syncupcnt_bcd2 #(
    parameter int unsigned MAX_TENS = 5,
    parameter int unsigned MAX_ONES = 9,
    parameter bit          WRAP     = 1'b1
) (
    input  logic       clk_counter,
    input  logic       reset,
    input  logic       en,
    input  logic       pause,
    input  logic       setting,
    input  logic       pb_set,
    input  logic       stop,
    output logic [3:0] q_ones,
    output logic [3:0] q_tens,
    output logic [3:0] preset_ones,
    output logic [3:0] preset_tens,
    output logic       carry_out,
    output logic       done
);

    localparam logic [3:0] LIM_T = 4'(MAX_TENS);
    localparam logic [3:0] LIM_O = 4'(MAX_ONES);

    typedef enum logic [1:0] {
        RUN,
        SET,
        HOLD,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] pones_q, pones_d;
    logic [3:0] ptens_q, ptens_d;
    logic       carry_q, carry_d;
    logic       done_q, done_d;

    logic       at_lim;
    logic [3:0] inc_ones;
    logic [3:0] inc_tens;

    // The limit test comes first so a limit below x9 never lets ones run past it.
    always_comb begin
        at_lim   = (tens_q == LIM_T) && (ones_q == LIM_O);
        inc_ones = ones_q;
        inc_tens = tens_q;
        if (at_lim) begin
            inc_ones = 4'd0;
            inc_tens = 4'd0;
        end else if (ones_q == 4'd9) begin
            inc_ones = 4'd0;
            inc_tens = tens_q + 4'd1;
        end else begin
            inc_ones = ones_q + 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        pones_d = pones_q;
        ptens_d = ptens_q;
        carry_d = 1'b0;
        done_d  = done_q;
        if (setting) begin
            state_d = SET;
            done_d  = 1'b0;
            if (pb_set) begin
                ones_d  = inc_ones;
                tens_d  = inc_tens;
                pones_d = inc_ones;
                ptens_d = inc_tens;
            end
        end else if (stop) begin
            state_d = HOLD;
            done_d  = 1'b0;
            ones_d  = pones_q;
            tens_d  = ptens_q;
        end else if (state_q == DONE) begin
            done_d = 1'b1;
        end else begin
            state_d = RUN;
            if (en && !pause) begin
                if (at_lim && !WRAP) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    ones_d  = inc_ones;
                    tens_d  = inc_tens;
                    carry_d = at_lim;
                end
            end
        end
    end

    always_ff @(posedge clk_counter or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            pones_q <= 4'd0;
            ptens_q <= 4'd0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            pones_q <= pones_d;
            ptens_q <= ptens_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

    assign q_ones      = ones_q;
    assign q_tens      = tens_q;
    assign preset_ones = pones_q;
    assign preset_tens = ptens_q;
    assign carry_out   = carry_q;
    assign done        = done_q;

endmodule
